// File: rtl/zxiznet_pkg.sv
// Shared definitions for the ZX-bus interrupt generator: FSM encoding,
// parameter defaults and the counter sizing helper.
package zxiznet_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int INT_LEN_DEF     = 32;
    localparam int HOLDOFF_DEF     = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } int_state_e;

    // One counter serves both phases, so it is sized for the longer of the two loads.
    function automatic int cnt_width(input int len_a, input int len_b);
        int longest;
        longest   = (len_a > len_b) ? len_a : len_b;
        cnt_width = $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/zx_sync.sv
// N-stage flip-flop synchroniser for one asynchronous input line, with a
// per-instance reset value so active-low lines can reset to their idle level.
module zx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift chain: bit 0 samples the raw line, the top bit is the safe output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/zxbus_intgen.sv
// ZX-bus /INT generator: synchronises chip IRQs and Z80 acknowledge, reports
// the enabled-source status bit and shapes /INT into a bounded pulse with hold-off.
module zxbus_intgen
    import zxiznet_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int INT_LEN     = INT_LEN_DEF,
    parameter int HOLDOFF     = HOLDOFF_DEF
) (
    input  logic clk,
    input  logic wrstb_n,
    input  logic ena_w5300_int,
    input  logic ena_sl811_int,
    input  logic ena_zxbus_int,
    input  logic w5300_int_n,
    input  logic sl811_intrq,
    input  logic zx_m1_n,
    input  logic zx_iorq_n,
    output logic zx_int_oe,
    output logic internal_int
);

    localparam int              CW        = cnt_width(INT_LEN, HOLDOFF);
    localparam logic [CW-1:0]   INT_LOAD  = CW'(INT_LEN - 1);
    localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLDOFF - 1);
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

    logic w5300_sync_s;
    logic sl811_sync_s;
    logic m1_sync_s;
    logic iorq_sync_s;
    logic w5300_s;
    logic sl811_s;
    logic ack_s;
    logic req_s;

    logic       internal_int_q;
    logic       int_oe_q;
    int_state_e state_q;
    int_state_e state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The W5300 line is active-low, so its chain resets to the inactive high level.
    zx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_w5300 (
        .clk_i (clk),
        .rst_i (wrstb_n),
        .d_i   (w5300_int_n),
        .q_o   (w5300_sync_s)
    );

    zx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sl811 (
        .clk_i (clk),
        .rst_i (wrstb_n),
        .d_i   (sl811_intrq),
        .q_o   (sl811_sync_s)
    );

    zx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_m1 (
        .clk_i (clk),
        .rst_i (wrstb_n),
        .d_i   (zx_m1_n),
        .q_o   (m1_sync_s)
    );

    zx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_iorq (
        .clk_i (clk),
        .rst_i (wrstb_n),
        .d_i   (zx_iorq_n),
        .q_o   (iorq_sync_s)
    );

    assign w5300_s = ~w5300_sync_s;
    assign sl811_s = sl811_sync_s;
    assign ack_s   = ~m1_sync_s & ~iorq_sync_s;
    assign req_s   = (ena_w5300_int & w5300_s) | (ena_sl811_int & sl811_s);

    // Status bit and /INT enable register; /INT follows the next-state so it drops with reset.
    always_ff @(posedge clk or posedge wrstb_n) begin
        if (wrstb_n) begin
            internal_int_q <= 1'b0;
            int_oe_q       <= 1'b0;
        end else begin
            internal_int_q <= req_s;
            int_oe_q       <= (state_d == ST_ASSERT);
        end
    end

    // FSM state and shared phase counter.
    always_ff @(posedge clk or posedge wrstb_n) begin
        if (wrstb_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: only ack, enable loss or timeout end a pulse; hold-off ignores requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (internal_int_q && ena_zxbus_int) begin
                    state_d = ST_ASSERT;
                    cnt_d   = INT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (ack_s || !ena_zxbus_int || (cnt_q == CNT_ZERO)) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign zx_int_oe    = int_oe_q;
    assign internal_int = internal_int_q;

endmodule

// File: tb/tb_zxbus_intgen.sv
// Randomised and directed bench for zxbus_intgen against a time-stamp based
// reference model of the synchronisers, status bit and /INT pulse shaping.
module tb_zxbus_intgen;

    localparam int N  = 2;
    localparam int IL = 32;
    localparam int HO = 64;

    logic clk = 1'b0;
    logic wrstb_n = 1'b1;
    logic ena_w5300_int = 1'b1;
    logic ena_sl811_int = 1'b1;
    logic ena_zxbus_int = 1'b1;
    logic w5300_int_n = 1'b0;
    logic sl811_intrq = 1'b0;
    logic zx_m1_n = 1'b1;
    logic zx_iorq_n = 1'b1;
    logic zx_int_oe;
    logic internal_int;

    int checks = 0;
    int errors = 0;

    // Reference model: delay lines for the synchronisers plus pulse time stamps.
    bit m_w_dl [N];
    bit m_s_dl [N];
    bit m_m_dl [N];
    bit m_i_dl [N];
    bit m_int;
    bit m_on;
    int m_start;
    int m_end;
    int k = 0;
    bit in_rst = 1'b1;

    zxbus_intgen #(.SYNC_STAGES(N), .INT_LEN(IL), .HOLDOFF(HO)) dut (
        .clk           (clk),
        .wrstb_n       (wrstb_n),
        .ena_w5300_int (ena_w5300_int),
        .ena_sl811_int (ena_sl811_int),
        .ena_zxbus_int (ena_zxbus_int),
        .w5300_int_n   (w5300_int_n),
        .sl811_intrq   (sl811_intrq),
        .zx_m1_n       (zx_m1_n),
        .zx_iorq_n     (zx_iorq_n),
        .zx_int_oe     (zx_int_oe),
        .internal_int  (internal_int)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at cycle %0d", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_w_dl[i] = 1'b1;
            m_s_dl[i] = 1'b0;
            m_m_dl[i] = 1'b0;
            m_i_dl[i] = 1'b0;
        end
        m_int   = 1'b0;
        m_on    = 1'b0;
        m_start = 0;
        m_end   = -100000;
    endtask

    task automatic model_edge();
        bit old_int;
        bit old_ack;
        old_int = m_int;
        old_ack = !m_m_dl[N-1] && !m_i_dl[N-1];
        m_int = (ena_w5300_int && !m_w_dl[N-1]) || (ena_sl811_int && m_s_dl[N-1]);
        for (int i = N-1; i > 0; i--) begin
            m_w_dl[i] = m_w_dl[i-1];
            m_s_dl[i] = m_s_dl[i-1];
            m_m_dl[i] = m_m_dl[i-1];
            m_i_dl[i] = m_i_dl[i-1];
        end
        m_w_dl[0] = w5300_int_n;
        m_s_dl[0] = sl811_intrq;
        m_m_dl[0] = zx_m1_n;
        m_i_dl[0] = zx_iorq_n;
        if (m_on) begin
            if (old_ack || !ena_zxbus_int || (k - m_start >= IL)) begin
                m_on  = 1'b0;
                m_end = k;
            end
        end else if (old_int && ena_zxbus_int && (k >= m_end + HO + 1)) begin
            // Hold-off lasts HO cycles, then one idle cycle re-arms the generator.
            m_on    = 1'b1;
            m_start = k;
        end
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        if (!in_rst) model_edge();
        #1;
        check_val("internal_int", {31'd0, internal_int}, {31'd0, m_int});
        check_val("zx_int_oe", {31'd0, zx_int_oe}, {31'd0, m_on});
    endtask

    task automatic run_until_oe(input logic want, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (zx_int_oe !== want && n < budget);
    endtask

    task automatic run_until_int(input logic want, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (internal_int !== want && n < budget);
    endtask

    task automatic apply_reset(input int hold);
        #2;
        wrstb_n = 1'b1;
        in_rst  = 1'b1;
        model_reset();
        #1;
        check_val("rst_async_oe", {31'd0, zx_int_oe}, 32'd0);
        check_val("rst_async_int", {31'd0, internal_int}, 32'd0);
        for (int i = 0; i < hold; i++) step();
        @(negedge clk);
        wrstb_n = 1'b0;
        in_rst  = 1'b0;
    endtask

    initial begin
        int n;
        int n2;
        model_reset();
        // Reset held with the W5300 IRQ active and every enable set.
        for (int i = 0; i < 3; i++) step();
        check_val("reset_oe", {31'd0, zx_int_oe}, 32'd0);
        check_val("reset_int", {31'd0, internal_int}, 32'd0);
        ena_sl811_int = 1'b0;
        @(negedge clk);
        wrstb_n = 1'b0;
        in_rst  = 1'b0;

        // W5300 IRQ: latency, pulse length, gap and level re-trigger.
        run_until_int(1'b1, 20, n);
        check_val("lat_internal", n, N + 1);
        run_until_oe(1'b1, 20, n2);
        check_val("lat_oe", n + n2, N + 2);
        run_until_oe(1'b0, 100, n);
        check_val("pulse_len", n, IL);
        run_until_oe(1'b1, 200, n);
        check_val("gap_len", n, HO + 1);

        // Acknowledge cuts the pulse short.
        for (int i = 0; i < 3; i++) step();
        zx_m1_n = 1'b0;
        zx_iorq_n = 1'b0;
        run_until_oe(1'b0, 50, n);
        check_val("ack_lat", n, N + 1);
        zx_m1_n = 1'b1;
        zx_iorq_n = 1'b1;
        run_until_oe(1'b1, 200, n);
        check_val("ack_gap", n + N + 1, HO + 1 + N + 1);

        // Source dropping mid-pulse keeps the full length.
        w5300_int_n = 1'b1;
        run_until_oe(1'b0, 100, n);
        check_val("drop_len", n, IL);
        for (int i = 0; i < HO + 8; i++) step();

        // Masking of the SL811 source and of the bus driver.
        sl811_intrq = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check_val("mask_int", {31'd0, internal_int}, 32'd0);
        check_val("mask_oe", {31'd0, zx_int_oe}, 32'd0);
        ena_sl811_int = 1'b1;
        ena_zxbus_int = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_val("nobus_int", {31'd0, internal_int}, 32'd1);
        check_val("nobus_oe", {31'd0, zx_int_oe}, 32'd0);

        // Enable drop at pulse clock 10, then re-enable during hold-off.
        ena_zxbus_int = 1'b1;
        run_until_oe(1'b1, 20, n);
        check_val("en_lat", n, 1);
        for (int i = 0; i < 9; i++) step();
        ena_zxbus_int = 1'b0;
        step();
        check_val("en_drop_oe", {31'd0, zx_int_oe}, 32'd0);
        for (int i = 0; i < 3; i++) step();
        ena_zxbus_int = 1'b1;
        run_until_oe(1'b1, 200, n);
        check_val("en_gap", n + 3, HO + 1);

        // Asynchronous reset at pulse clock 5.
        for (int i = 0; i < 4; i++) step();
        apply_reset(1);
        run_until_oe(1'b1, 20, n);
        check_val("post_rst_lat", n, N + 2);

        // Randomised traffic with occasional resets and acknowledges.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) w5300_int_n = ~w5300_int_n;
            if ($urandom_range(0, 15) == 0) sl811_intrq = ~sl811_intrq;
            if ($urandom_range(0, 63) == 0) ena_w5300_int = ~ena_w5300_int;
            if ($urandom_range(0, 63) == 0) ena_sl811_int = ~ena_sl811_int;
            if ($urandom_range(0, 99) == 0) ena_zxbus_int = ~ena_zxbus_int;
            if ($urandom_range(0, 40) == 0) begin
                zx_m1_n = 1'b0;
                zx_iorq_n = 1'b0;
            end else begin
                zx_m1_n = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
                zx_iorq_n = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            end
            if ($urandom_range(0, 999) == 0) apply_reset($urandom_range(0, 2));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
